// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, LSB-first shifting on
// device clock falls, odd parity, stop bit and ACK check.
// Optional feature macro: PS2_TX_TIMEOUT_EN (15 ms first-edge / 2 ms frame timeout).
module ps2_host_tx #(
   parameter int unsigned CLK_FREQ   = 28_000_000,
   parameter int unsigned INHIBIT_US = 120,
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic       clk28,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   // 64-bit intermediate: CLK_FREQ * INHIBIT_US can exceed 32 bits
   localparam longint unsigned InhCycL =
      (64'(CLK_FREQ) * 64'(INHIBIT_US)) / 64'd1_000_000;
   localparam int unsigned InhCyc = 32'(InhCycL);
   localparam int unsigned InhW   = (InhCyc > 2) ? $clog2(InhCyc) : 2;
   localparam int unsigned FiltW  = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {StIdle, StInhibit, StSend, StAck, StWaitIdle} state_e;

   // Index 0 = clock pin, index 1 = data pin
   logic [1:0]       clk_sync_q;
   logic [1:0]       dat_sync_q;
   logic [1:0]       raw_s;
   logic [1:0]       filt_q;
   logic [FiltW-1:0] fcnt_q [2];
   logic             clk_fall_q;

   state_e           state_q;
   logic [10:0]      shift_q;
   logic [3:0]       bitcnt_q;
   logic [InhW-1:0]  inh_q;
   logic             err_q;
   logic             clk_oe_q;
   logic             dat_oe_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;

   // Two-stage synchronizers; idle line level is high
   always_ff @(posedge clk28) begin
      if (rst) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
         dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      end
   end

   assign raw_s = {dat_sync_q[1], clk_sync_q[1]};

   // Glitch filter: accept a new level after FILTER_LEN consecutive samples
   always_ff @(posedge clk28) begin
      if (rst) begin
         filt_q     <= 2'b11;
         fcnt_q[0]  <= '0;
         fcnt_q[1]  <= '0;
         clk_fall_q <= 1'b0;
      end else begin
         clk_fall_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (raw_s[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == FiltW'(FILTER_LEN - 1)) begin
               fcnt_q[i] <= '0;
               filt_q[i] <= raw_s[i];
               if (i == 0 && !raw_s[i]) clk_fall_q <= 1'b1;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + FiltW'(1);
            end
         end
      end
   end

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned ToFirst = 32'((64'(CLK_FREQ) * 64'd15) / 64'd1000);
   localparam int unsigned ToAck   = 32'((64'(CLK_FREQ) * 64'd2) / 64'd1000);

   logic [18:0] to_q;
   logic        to_exp;

   // Timeout counter: runs from end of inhibit, restarts at the first device clock fall
   always_ff @(posedge clk28) begin
      if (rst || state_q == StIdle || state_q == StInhibit) begin
         to_q <= '0;
      end else if (state_q == StSend && bitcnt_q == 4'd0 && clk_fall_q) begin
         to_q <= '0;
      end else begin
         to_q <= to_q + 19'd1;
      end
   end

   // Expiry limit depends on whether the device has started clocking yet
   always_comb begin
      to_exp = 1'b0;
      if (state_q == StSend && bitcnt_q == 4'd0) begin
         to_exp = (to_q == 19'(ToFirst - 1));
      end else if (state_q == StSend || state_q == StAck || state_q == StWaitIdle) begin
         to_exp = (to_q == 19'(ToAck - 1));
      end
   end
`endif

   // Transmit FSM with registered outputs
   always_ff @(posedge clk28) begin
      if (rst) begin
         state_q  <= StIdle;
         shift_q  <= '0;
         bitcnt_q <= '0;
         inh_q    <= '0;
         err_q    <= 1'b0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               if (tx_valid && ready_q) begin
                  // Bit 10 is never presented; stop, parity and data sit below it
                  shift_q  <= {2'b01, ~^tx_data, tx_data};
                  bitcnt_q <= '0;
                  inh_q    <= '0;
                  err_q    <= 1'b0;
                  clk_oe_q <= 1'b1;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= StInhibit;
               end
            end
            StInhibit: begin
               // Pull data low one cycle before releasing clock: that is the start bit
               if (inh_q == InhW'(InhCyc - 2)) dat_oe_q <= 1'b1;
               if (inh_q == InhW'(InhCyc - 1)) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b1;
                  state_q  <= StSend;
               end else begin
                  inh_q <= inh_q + InhW'(1);
               end
            end
            StSend: begin
               if (clk_fall_q) begin
                  dat_oe_q <= ~shift_q[0];
                  shift_q  <= {1'b1, shift_q[10:1]};
                  bitcnt_q <= bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd9) state_q <= StAck;
               end
            end
            StAck: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               if (clk_fall_q) begin
                  state_q <= StWaitIdle;
                  if (filt_q[1]) begin
                     err_q   <= 1'b1;
                     error_q <= 1'b1;
                  end
               end
            end
            StWaitIdle: begin
               if (filt_q == 2'b11) begin
                  done_q  <= ~err_q;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         if (to_exp) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b1;
            state_q  <= StIdle;
         end
`endif
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign tx_ready   = ready_q;
   assign busy       = busy_q;
   assign tx_done    = done_q;
   assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, keyboard device model,
// frame/strobe reference model and a per-cycle protocol monitor.
module tb_ps2_host_tx;

   localparam int unsigned TbClk   = 1_000_000;
   localparam int unsigned TbInhUs = 100;
   localparam int unsigned TbFilt  = 8;
   localparam int          InhCyc  = (TbClk / 1000) * TbInhUs / 1000;
`ifdef PS2_TX_TIMEOUT_EN
   localparam int          ToFirst = (TbClk / 1000) * 15;
`endif

   logic       clk28;
   logic       rst;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_error;

   logic       dev_clk_lo;
   logic       dev_dat_lo;
   logic       glitch_lo;
   logic [10:0] dev_fr;
   bit         dev_ok;

   int n_checks;
   int n_fail;
   int done_cnt;
   int err_cnt;
   int inh_cnt;

   // Open-drain wired-AND with pull-ups
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_lo | glitch_lo);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_lo);

   ps2_host_tx #(
      .CLK_FREQ   (TbClk),
      .INHIBIT_US (TbInhUs),
      .FILTER_LEN (TbFilt)
   ) u_dut (
      .clk28      (clk28),
      .rst        (rst),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error)
   );

   initial begin
      clk28 = 1'b0;
      forever #5 clk28 = ~clk28;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time budget exhausted, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk28);
      #1;
   endtask

   // Reference frame as seen on the data line: start, data LSB first, odd parity, stop
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic par;
      par = (($countones(d) % 2) == 0);
      frame_of = {1'b1, par, d, 1'b0};
   endfunction

   // Per-cycle protocol monitor
   initial begin
      bit p_acc;
      bit p_clk;
      bit p_dat;
      bit p_done;
      int run;
      p_acc = 0; p_clk = 0; p_dat = 0; p_done = 0; run = 0;
      forever begin
         @(negedge clk28);
         if (rst) begin
            p_acc = 0; p_clk = 0; p_dat = 0; p_done = 0; run = 0;
         end else begin
            check("ready_is_not_busy", 32'(tx_ready), 32'(!busy));
            check("strobes_exclusive", 32'(tx_done & tx_error), 0);
            if (tx_ready) check("idle_oe_released", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
            if (p_acc) check("accept_to_clk_oe", 32'(ps2_clk_oe), 1);
            if (p_done) check("ready_after_done", 32'(tx_ready), 1);
            if (ps2_clk_oe && !p_clk) begin
               inh_cnt++;
               check("dat_oe_low_at_inhibit_start", 32'(ps2_dat_oe), 0);
            end
            if (ps2_clk_oe) run++;
            if (p_clk && !ps2_clk_oe) begin
               check("inhibit_length", run, InhCyc);
               check("start_bit_in_last_inhibit_cycle", 32'(p_dat), 1);
               run = 0;
            end
            done_cnt += int'(tx_done);
            err_cnt  += int'(tx_error);
            p_acc  = tx_valid && tx_ready;
            p_clk  = ps2_clk_oe;
            p_dat  = ps2_dat_oe;
            p_done = tx_done;
         end
      end
   end

   // Hold tx_valid until accepted, then scramble tx_data to prove capture
   task automatic start(input logic [7:0] d);
      int t;
      t = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      while (!busy && t < 100) begin
         tick(1);
         t++;
      end
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      check("accepted", 32'(busy), 1);
   endtask

   // Keyboard receiving a host command; abort_edge > 0 stops after that clock fall
   task automatic dev_frame(input int half, input bit ack, input bit glitch,
                            input int abort_edge);
      int t;
      dev_ok = 1'b0;
      dev_fr = '0;
      t = 0;
      while (ps2_clk_in !== 1'b0 && t < 5000) begin
         tick(1);
         t++;
      end
      while (ps2_clk_in !== 1'b1 && t < 5000) begin
         tick(1);
         t++;
      end
      check("rts_within_bound", 32'(t < 5000), 1);
      if (t >= 5000) return;
      tick(half);
      dev_fr[0] = ps2_dat_in;
      for (int e = 1; e <= 10; e++) begin
         dev_clk_lo = 1'b1;
         tick(half);
         dev_clk_lo = 1'b0;
         if (e == abort_edge) return;
         dev_fr[e] = ps2_dat_in;
         if (glitch) begin
            tick(half / 3);
            glitch_lo = 1'b1;
            tick(3);
            glitch_lo = 1'b0;
            tick(half - half / 3 - 3);
         end else begin
            tick(half);
         end
      end
      dev_dat_lo = ack;
      tick(half / 2);
      dev_clk_lo = 1'b1;
      tick(half);
      dev_clk_lo = 1'b0;
      tick(half / 2);
      dev_dat_lo = 1'b0;
      dev_ok = 1'b1;
   endtask

   task automatic do_xfer(input logic [7:0] d, input int half, input bit ack,
                          input bit glitch, input bit poke);
      int d0;
      int e0;
      int i0;
      int t;
      d0 = done_cnt;
      e0 = err_cnt;
      i0 = inh_cnt;
      start(d);
      fork
         dev_frame(half, ack, glitch, 0);
         if (poke) begin
            tick(400);
            check("poke_while_busy", 32'(busy), 1);
            tx_data  = ~d;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
         end
      join
      check("device_frame_complete", 32'(dev_ok), 1);
      check("frame_on_line", 32'(dev_fr), 32'(frame_of(d)));
      t = 0;
      while (!tx_ready && t < 3000) begin
         tick(1);
         t++;
      end
      check("ready_returns", 32'(tx_ready), 1);
      tick(30);
      check("done_count", done_cnt - d0, 32'(ack));
      check("error_count", err_cnt - e0, 32'(!ack));
      check("one_transfer", inh_cnt - i0, 1);
   endtask

   initial begin
      logic [7:0] rd;
      int rh;
      bit ra;
      bit rg;
      int d0;
      int e0;
      int cnt;
      n_checks = 0; n_fail = 0; done_cnt = 0; err_cnt = 0; inh_cnt = 0;
      rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      dev_clk_lo = 1'b0; dev_dat_lo = 1'b0; glitch_lo = 1'b0;
      tick(5);
      rst = 1'b0;
      @(negedge clk28);
      check("reset_clk_oe", 32'(ps2_clk_oe), 0);
      check("reset_dat_oe", 32'(ps2_dat_oe), 0);
      check("reset_tx_ready", 32'(tx_ready), 1);
      check("reset_busy", 32'(busy), 0);
      check("reset_tx_done", 32'(tx_done), 0);
      check("reset_tx_error", 32'(tx_error), 0);
      tick(3);

      // 0xED with ACK; line order pinned by hand
      do_xfer(8'hED, 40, 1'b1, 1'b0, 1'b0);
      check("frame_0xED_literal", 32'(dev_fr), 32'(11'h7DA));

      // 0x00 with NACK: parity bit must be 1
      do_xfer(8'h00, 40, 1'b0, 1'b0, 1'b0);
      check("frame_0x00_literal", 32'(dev_fr), 32'(11'h600));
      check("parity_0x00", 32'(dev_fr[9]), 1);

      // tx_valid pulse while busy is ignored
      do_xfer(8'h5A, 40, 1'b1, 1'b0, 1'b1);

      // 3-cycle clock glitches during SEND
      do_xfer(8'hC3, 45, 1'b1, 1'b1, 1'b0);

      // Reset after edge 5 aborts the transfer
      d0 = done_cnt;
      e0 = err_cnt;
      start(8'hA5);
      dev_frame(40, 1'b1, 1'b0, 5);
      rst = 1'b1;
      tick(1);
      check("abort_clk_oe", 32'(ps2_clk_oe), 0);
      check("abort_dat_oe", 32'(ps2_dat_oe), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_tx_done", 32'(tx_done), 0);
      check("abort_tx_error", 32'(tx_error), 0);
      rst = 1'b0;
      tick(40);
      check("abort_no_strobes", (done_cnt - d0) + (err_cnt - e0), 0);
      do_xfer(8'hFF, 40, 1'b1, 1'b0, 1'b0);
      check("frame_0xFF_literal", 32'(dev_fr), 32'(11'h7FE));

      // Randomized traffic
      for (int k = 0; k < 8; k++) begin
         rd = 8'($urandom);
         rh = int'($urandom_range(30, 50));
         ra = ($urandom_range(0, 3) != 0);
         rg = 1'($urandom_range(0, 1));
         do_xfer(rd, rh, ra, rg, 1'b0);
      end

      // Silent device
      d0 = done_cnt;
      e0 = err_cnt;
      start(8'h3C);
      cnt = 0;
      while (ps2_clk_oe && cnt < 1000) begin
         tick(1);
         cnt++;
      end
`ifdef PS2_TX_TIMEOUT_EN
      cnt = 0;
      while (!tx_error && cnt < 30000) begin
         tick(1);
         cnt++;
      end
      check("timeout_latency_window",
            32'((cnt >= ToFirst - int'(TbFilt) - 2) && (cnt <= ToFirst + int'(TbFilt) + 2)), 1);
      check("timeout_oe_released", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
      tick(1);
      check("timeout_ready", 32'(tx_ready), 1);
      tick(5);
      check("timeout_error_count", err_cnt - e0, 1);
      check("timeout_no_done", done_cnt - d0, 0);
`else
      cnt = 0;
      for (int k = 0; k < 5000; k++) begin
         tick(1);
         if (busy) cnt++;
      end
      check("busy_held_without_clocks", cnt, 5000);
      check("silent_no_strobes", (done_cnt - d0) + (err_cnt - e0), 0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2);
      check("silent_abort_ready", 32'(tx_ready), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
